// File: rtl/pb_ram_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM between two PicoBlaze requesters.
// An optional per-access lock holds ownership for atomic read-modify-write sequences.
module pb_ram_arbiter #(
    parameter int unsigned ADDR_W  = 1,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LOCK_TO = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              owner,
    output logic              lock_err
);

    localparam int unsigned CNT_W = $clog2(LOCK_TO + 1);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t           state, state_nx;
    logic             last_grant, last_grant_nx;
    logic [CNT_W-1:0] to_cnt, to_cnt_nx;
    logic             gnt0_nx, gnt1_nx, lock_err_nx;
    logic             elig0, elig1;

    // A requester is not re-sampled at the edge that ends its own grant cycle.
    assign elig0 = req0 & ~gnt0;
    assign elig1 = req1 & ~gnt1;

    // Read data is forwarded straight from the RAM while the strobe is up.
    assign rdata0 = rvalid0 ? ram_dout : '0;
    assign rdata1 = rvalid1 ? ram_dout : '0;

    // Grant selection, lock tracking and lock timeout.
    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        to_cnt_nx     = to_cnt;
        gnt0_nx       = 1'b0;
        gnt1_nx       = 1'b0;
        lock_err_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (elig0 && (!elig1 || last_grant)) gnt0_nx = 1'b1;
                else if (elig1)                      gnt1_nx = 1'b1;
            end
            LOCK0:   gnt0_nx = elig0;
            LOCK1:   gnt1_nx = elig1;
            default: state_nx = IDLE;
        endcase

        if (gnt0_nx) begin
            last_grant_nx = 1'b0;
            to_cnt_nx     = '0;
            state_nx      = lock0 ? LOCK0 : IDLE;
        end else if (gnt1_nx) begin
            last_grant_nx = 1'b1;
            to_cnt_nx     = '0;
            state_nx      = lock1 ? LOCK1 : IDLE;
        end else if (state == LOCK0 || state == LOCK1) begin
            if (to_cnt == CNT_W'(LOCK_TO - 1)) begin
                state_nx      = IDLE;
                lock_err_nx   = 1'b1;
                to_cnt_nx     = '0;
                last_grant_nx = (state == LOCK1);
            end else begin
                to_cnt_nx = to_cnt + CNT_W'(1);
            end
        end
    end

    // State and registered RAM-side / requester-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            to_cnt     <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            owner      <= 1'b0;
            lock_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            to_cnt     <= to_cnt_nx;
            gnt0       <= gnt0_nx;
            gnt1       <= gnt1_nx;
            rvalid0    <= gnt0 & ~ram_we;
            rvalid1    <= gnt1 & ~ram_we;
            ram_en     <= gnt0_nx | gnt1_nx;
            lock_err   <= lock_err_nx;
            if (gnt0_nx) begin
                ram_we   <= we0;
                ram_addr <= addr0;
                ram_din  <= wdata0;
                owner    <= 1'b0;
            end else if (gnt1_nx) begin
                ram_we   <= we1;
                ram_addr <= addr1;
                ram_din  <= wdata1;
                owner    <= 1'b1;
            end else begin
                ram_we   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pb_ram_arbiter.sv
// Directed bench for pb_ram_arbiter: per-cycle vector table plus hand-written
// lock-timeout and reset-during-read sequences, with a behavioural RAM attached.
module tb_pb_ram_arbiter;

    localparam int unsigned ADDR_W = 1;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NROWS  = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, we0, lock0, req1, we1, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              ram_en, ram_we, owner, lock_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pb_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_TO(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .owner(owner), .lock_err(lock_err)
    );

    // Single-port synchronous RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    typedef struct {
        logic       rst;
        logic       r0, w0, a0;
        logic [7:0] d0;
        logic       l0;
        logic       r1, w1, a1;
        logic [7:0] d1;
        logic       l1;
        logic       g0, g1, en, we, ad;
        logic [7:0] din;
        logic       v0;
        logic [7:0] q0;
        logic       v1;
        logic [7:0] q1;
        logic       own, lerr;
    } vec_t;

    vec_t tbl [NROWS];

    function automatic vec_t mk(input int rst, r0, w0, a0, d0, l0, r1, w1, a1, d1, l1,
                                input int g0, g1, en, we, ad, din, v0, q0, v1, q1, own, lerr);
        vec_t v;
        v.rst = 1'(rst);
        v.r0 = 1'(r0); v.w0 = 1'(w0); v.a0 = 1'(a0); v.d0 = 8'(d0); v.l0 = 1'(l0);
        v.r1 = 1'(r1); v.w1 = 1'(w1); v.a1 = 1'(a1); v.d1 = 8'(d1); v.l1 = 1'(l1);
        v.g0 = 1'(g0); v.g1 = 1'(g1); v.en = 1'(en); v.we = 1'(we); v.ad = 1'(ad);
        v.din = 8'(din); v.v0 = 1'(v0); v.q0 = 8'(q0); v.v1 = 1'(v1); v.q1 = 8'(q1);
        v.own = 1'(own); v.lerr = 1'(lerr);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst;
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0; lock0 = v.l0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1; lock1 = v.l1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; lock0 = 1'b0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; lock1 = 1'b0;
    endtask

    task automatic check_row(input int i, input vec_t v);
        check($sformatf("row%0d gnt0", i),     32'(gnt0),     32'(v.g0));
        check($sformatf("row%0d gnt1", i),     32'(gnt1),     32'(v.g1));
        check($sformatf("row%0d ram_en", i),   32'(ram_en),   32'(v.en));
        check($sformatf("row%0d ram_we", i),   32'(ram_we),   32'(v.we));
        check($sformatf("row%0d ram_addr", i), 32'(ram_addr), 32'(v.ad));
        if (v.we) check($sformatf("row%0d ram_din", i), 32'(ram_din), 32'(v.din));
        check($sformatf("row%0d rvalid0", i),  32'(rvalid0),  32'(v.v0));
        check($sformatf("row%0d rdata0", i),   32'(rdata0),   32'(v.q0));
        check($sformatf("row%0d rvalid1", i),  32'(rvalid1),  32'(v.v1));
        check($sformatf("row%0d rdata1", i),   32'(rdata1),   32'(v.q1));
        check($sformatf("row%0d owner", i),    32'(owner),    32'(v.own));
        check($sformatf("row%0d lock_err", i), 32'(lock_err), 32'(v.lerr));
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  stray_gnt1;

        mem[0] = 8'h00;
        mem[1] = 8'h5A;
        ram_dout = '0;

        //            rst r0 w0 a0 d0    l0 r1 w1 a1 d1    l1   g0 g1 en we ad din   v0 q0    v1 q1    own le
        tbl[0]  = mk(1,  0, 0, 0, 0,    0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0,    0, 0,    0, 0,    0, 0);
        // single read of RAM[1]; req0 still high at the end of its grant cycle is ignored
        tbl[1]  = mk(0,  1, 0, 1, 0,    0, 0, 0, 0, 0,    0,   1, 0, 1, 0, 1, 0,    0, 0,    0, 0,    0, 0);
        tbl[2]  = mk(0,  1, 0, 1, 0,    0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 1, 0,    1, 'h5A, 0, 0,    0, 0);
        tbl[3]  = mk(0,  0, 0, 0, 0,    0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 1, 0,    0, 0,    0, 0,    0, 0);
        // tie after reset alternates 0,1,0,1; r1 writes A5 to addr 0, r0 reads it back
        tbl[4]  = mk(1,  0, 0, 0, 0,    0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0,    0, 0,    0, 0,    0, 0);
        tbl[5]  = mk(0,  1, 0, 0, 0,    0, 1, 1, 0, 'hA5, 0,   1, 0, 1, 0, 0, 0,    0, 0,    0, 0,    0, 0);
        tbl[6]  = mk(0,  1, 0, 0, 0,    0, 1, 1, 0, 'hA5, 0,   0, 1, 1, 1, 0, 'hA5, 1, 'h00, 0, 0,    1, 0);
        tbl[7]  = mk(0,  1, 0, 0, 0,    0, 1, 1, 0, 'hA5, 0,   1, 0, 1, 0, 0, 0,    0, 0,    0, 0,    0, 0);
        tbl[8]  = mk(0,  1, 0, 0, 0,    0, 1, 1, 0, 'hA5, 0,   0, 1, 1, 1, 0, 'hA5, 1, 'hA5, 0, 0,    1, 0);
        tbl[9]  = mk(0,  0, 0, 0, 0,    0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0,    0, 0,    0, 0,    1, 0);
        // locked read-modify-write by r0 while r1 waits
        tbl[10] = mk(0,  1, 0, 0, 0,    1, 1, 0, 0, 0,    0,   1, 0, 1, 0, 0, 0,    0, 0,    0, 0,    0, 0);
        tbl[11] = mk(0,  1, 1, 0, 'h3C, 0, 1, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0,    1, 'hA5, 0, 0,    0, 0);
        tbl[12] = mk(0,  1, 1, 0, 'h3C, 0, 1, 0, 0, 0,    0,   1, 0, 1, 1, 0, 'h3C, 0, 0,    0, 0,    0, 0);
        tbl[13] = mk(0,  0, 0, 0, 0,    0, 1, 0, 0, 0,    0,   0, 1, 1, 0, 0, 0,    0, 0,    0, 0,    1, 0);
        tbl[14] = mk(0,  0, 0, 0, 0,    0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0,    0, 0,    1, 'h3C, 1, 0);

        for (int i = 0; i < int'(NROWS); i++) begin
            drive(tbl[i]);
            @(posedge clk);
            @(negedge clk);
            check_row(i, tbl[i]);
        end

        // Lock timeout: r0 locks then goes quiet; r1 must wait out 16 idle cycles.
        idle_inputs();
        req0 = 1'b1; lock0 = 1'b1; addr0 = 1'b1;
        req1 = 1'b1; addr1 = 1'b1;
        @(negedge clk);
        check("to gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0; lock0 = 1'b0;
        n = 0; seen = 1'b0; stray_gnt1 = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            n++;
            if (lock_err) seen = 1'b1;
            else if (gnt1) stray_gnt1 = 1'b1;
        end
        check("to lock_err seen", 32'(seen), 32'd1);
        check("to idle cycles", 32'(n), 32'd16);
        check("to no gnt1 during lock", 32'(stray_gnt1), 32'd0);
        check("to gnt1 with lock_err", 32'(gnt1), 32'd0);
        @(negedge clk);
        check("to lock_err one cycle", 32'(lock_err), 32'd0);
        check("to gnt1 after release", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        @(negedge clk);

        // Reset during the grant cycle of a read discards the response.
        req0 = 1'b1; addr0 = 1'b1; we0 = 1'b0;
        @(negedge clk);
        check("rst gnt0", 32'(gnt0), 32'd1);
        reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        check("rst rvalid0", 32'(rvalid0), 32'd0);
        check("rst outputs", 32'({gnt0, gnt1, ram_en, ram_we, ram_addr, ram_din, rvalid1, owner, lock_err, rdata0}),
              32'd0);
        @(negedge clk);
        check("rst rvalid0 later", 32'(rvalid0), 32'd0);
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        check("rst tie gnt0", 32'(gnt0), 32'd1);
        check("rst tie gnt1", 32'(gnt1), 32'd0);
        idle_inputs();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
